ptw_axi_reader: RTL and testbench

Page-table-walk read responder for the instruction TLB. It accepts single-cycle PTE fetch requests from the TLB walker and issues each one as a single-beat AXI4 read (AR/R channels only). It returns the 32-bit PTE with a one-cycle valid pulse. It sits between the TLB's walker-request port and the shared AXI interconnect, and it converts AXI error responses into a PTE value the walker treats as a page fault.

---
 rtl/ptw_pkg.sv | 17 +
 rtl/ptw_axi_reader_if.sv | 24 ++
 rtl/ptw_axi_reader.sv | 122 ++++++++++++
 tb/tb_ptw_axi_reader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_pkg.sv
// Shared types and constants for the page-table-walk AXI reader.
package ptw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_DRAIN = 2'd3
    } ptw_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int PTE_V_BIT = 0;

endpackage

// File: rtl/ptw_axi_reader_if.sv
// AXI4 read-only (AR/R) channel bundle used by the PTW reader.
interface ptw_axi_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  M_ARVALID;
    logic [ADDR_WIDTH-1:0] M_ARADDR;
    logic [2:0]            M_ARPROT;
    logic                  M_ARREADY;
    logic                  M_RVALID;
    logic [DATA_WIDTH-1:0] M_RDATA;
    logic [1:0]            M_RRESP;
    logic                  M_RREADY;

    modport master (
        output M_ARVALID, M_ARADDR, M_ARPROT, M_RREADY,
        input  M_ARREADY, M_RVALID, M_RDATA, M_RRESP
    );

    modport slave (
        input  M_ARVALID, M_ARADDR, M_ARPROT, M_RREADY,
        output M_ARREADY, M_RVALID, M_RDATA, M_RRESP
    );
endinterface

// File: rtl/ptw_axi_reader.sv
// ITLB walker PTE fetch: one single-beat AXI read per request, one pending slot.
module ptw_axi_reader
    import ptw_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [2:0]  AR_PROT    = 3'b001
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                  ABORT,
    output logic                  RESP_VALID,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic                  RESP_ERR,
    ptw_axi_reader_if.master      m_axi
);

    ptw_state_t            state;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  pend_full;
    logic                  ar_done;
    logic [ADDR_WIDTH-1:0] req_aligned;
    logic [DATA_WIDTH-1:0] fault_pte;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  r_okay;

    assign req_aligned = {REQ_ADDR[ADDR_WIDTH-1:2], 2'b00};

    // An error PTE must have V clear so the walker raises a page fault.
    always_comb begin
        fault_pte            = '0;
        fault_pte[PTE_V_BIT] = 1'b0;
    end

    // In DRAIN, ar_done tells whether the AR beat already went out.
    assign m_axi.M_ARVALID = (state == ST_AR) ||
                             (state == ST_DRAIN && !ar_done);
    assign m_axi.M_RREADY  = (state == ST_R) ||
                             (state == ST_DRAIN && ar_done);
    assign m_axi.M_ARADDR  = ar_addr;
    assign m_axi.M_ARPROT  = AR_PROT;

    assign ar_hs  = m_axi.M_ARVALID && m_axi.M_ARREADY;
    assign r_hs   = m_axi.M_RREADY && m_axi.M_RVALID;
    assign r_okay = (m_axi.M_RRESP == AXI_RESP_OKAY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            ar_addr    <= '0;
            pend_addr  <= '0;
            pend_full  <= 1'b0;
            ar_done    <= 1'b0;
            RESP_VALID <= 1'b0;
            RESP_DATA  <= '0;
            RESP_ERR   <= 1'b0;
        end else begin
            RESP_VALID <= 1'b0;

            if (ABORT) begin
                pend_full <= 1'b0;
            end else if (state != ST_IDLE && REQ_VALID && !pend_full) begin
                pend_full <= 1'b1;
                pend_addr <= req_aligned;
            end

            unique case (state)
                ST_IDLE: begin
                    if (ABORT) begin
                        state <= ST_IDLE;
                    end else if (pend_full) begin
                        ar_addr <= pend_addr;
                        state   <= ST_AR;
                        if (REQ_VALID) begin
                            pend_addr <= req_aligned;
                        end else begin
                            pend_full <= 1'b0;
                        end
                    end else if (REQ_VALID) begin
                        ar_addr <= req_aligned;
                        state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (ABORT) begin
                        ar_done <= ar_hs;
                        state   <= ST_DRAIN;
                    end else if (ar_hs) begin
                        state <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        state <= ST_IDLE;
                        if (!ABORT) begin
                            RESP_VALID <= 1'b1;
                            RESP_DATA  <= r_okay ? m_axi.M_RDATA : fault_pte;
                            RESP_ERR   <= !r_okay;
                        end
                    end else if (ABORT) begin
                        ar_done <= 1'b1;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!ar_done) begin
                        if (ar_hs) ar_done <= 1'b1;
                    end else if (r_hs) begin
                        ar_done <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_axi_reader.sv
// Scoreboard bench for ptw_axi_reader with a scripted AXI read slave.
module tb_ptw_axi_reader;
    import ptw_pkg::*;

    typedef struct {
        int          ar_wait;
        int          r_wait;
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        abort = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    beat_t bq[$];
    exp_t  sb[$];
    exp_t  mon_e;
    int    vectors = 0;
    int    miscompares = 0;
    int    resp_cnt = 0;
    int    ar_hs_cnt = 0;
    int    r_done = 0;
    bit    slv_kill = 1'b0;

    ptw_axi_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    ptw_axi_reader dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (req_valid),
        .REQ_ADDR   (req_addr),
        .ABORT      (abort),
        .RESP_VALID (resp_valid),
        .RESP_DATA  (resp_data),
        .RESP_ERR   (resp_err),
        .m_axi      (axi)
    );

    always #5 CLK = ~CLK;

    // Response monitor pops the scoreboard on every RESP_VALID pulse.
    always @(negedge CLK) begin
        if (!RST && resp_valid) begin
            resp_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_resp: got data=%h err=%b, required no pulse",
                         resp_data, resp_err);
            end else begin
                mon_e = sb.pop_front();
                if (resp_data !== mon_e.data || resp_err !== mon_e.err) begin
                    miscompares++;
                    $display("FAIL resp: got data=%h err=%b, required data=%h err=%b",
                             resp_data, resp_err, mon_e.data, mon_e.err);
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (!RST && axi.M_ARVALID && axi.M_ARREADY) ar_hs_cnt++;
    end

    // Scripted slave: one beat descriptor per observed AR request.
    initial begin : axi_slave
        beat_t       b;
        logic [31:0] a0;
        int          n;
        axi.M_ARREADY = 1'b0;
        axi.M_RVALID  = 1'b0;
        axi.M_RDATA   = '0;
        axi.M_RRESP   = '0;
        forever begin
            @(negedge CLK);
            if (!slv_kill && !RST && axi.M_ARVALID && bq.size() != 0) begin
                b  = bq.pop_front();
                a0 = axi.M_ARADDR;
                for (int i = 0; i < b.ar_wait && !slv_kill; i++) begin
                    @(negedge CLK);
                    vectors++;
                    if (axi.M_ARVALID !== 1'b1 || axi.M_ARADDR !== a0) begin
                        miscompares++;
                        $display("FAIL ar_hold: got arvalid=%b araddr=%h, required 1 %h",
                                 axi.M_ARVALID, axi.M_ARADDR, a0);
                    end
                end
                if (!slv_kill) axi.M_ARREADY = 1'b1;
                @(negedge CLK);
                axi.M_ARREADY = 1'b0;
                for (int i = 0; i < b.r_wait && !slv_kill; i++) @(negedge CLK);
                if (!slv_kill) begin
                    axi.M_RVALID = 1'b1;
                    axi.M_RDATA  = b.data;
                    axi.M_RRESP  = b.resp;
                    n = 0;
                    while (axi.M_RREADY !== 1'b1 && !slv_kill && n < 100) begin
                        @(negedge CLK);
                        n++;
                    end
                    if (!slv_kill && axi.M_RREADY === 1'b1) begin
                        @(negedge CLK);
                        r_done++;
                    end
                end
                axi.M_RVALID  = 1'b0;
                axi.M_RDATA   = '0;
                axi.M_RRESP   = '0;
                axi.M_ARREADY = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        req_addr  = '0;
    endtask

    task automatic wait_resp(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        vectors++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_resp: got v=%b d=%h e=%b, required 0 0 0",
                     resp_valid, resp_data, resp_err);
        end
        vectors++;
        if (axi.M_ARVALID !== 1'b0 || axi.M_ARADDR !== 32'h0 || axi.M_RREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_axi: got arv=%b ara=%h rr=%b, required 0 0 0",
                     axi.M_ARVALID, axi.M_ARADDR, axi.M_RREADY);
        end
        vectors++;
        if (axi.M_ARPROT !== 3'b001) begin
            miscompares++;
            $display("FAIL arprot: got %b, required 001", axi.M_ARPROT);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bq.push_back('{0, 0, 32'h0000_10CF, AXI_RESP_OKAY});
        sb.push_back('{32'h0000_10CF, 1'b0});
        send_req(32'h003E_8004);
        @(negedge CLK);
        vectors++;
        if (axi.M_ARVALID !== 1'b1 || axi.M_ARADDR !== 32'h003E_8004) begin
            miscompares++;
            $display("FAIL basic_ar: got arv=%b ara=%h, required 1 003e8004",
                     axi.M_ARVALID, axi.M_ARADDR);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (axi.M_RREADY !== 1'b1 || axi.M_ARVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_r: got rr=%b arv=%b, required 1 0",
                     axi.M_RREADY, axi.M_ARVALID);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: got resp_valid=%b at t+3, required 1", resp_valid);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0000_10CF || axi.M_RREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_hold: got v=%b d=%h rr=%b, required 0 000010cf 0",
                     resp_valid, resp_data, axi.M_RREADY);
        end
        tick();
    endtask

    task automatic test_ar_stall();
        int h0, c0, nav;
        bit bad, ok;
        h0 = ar_hs_cnt;
        c0 = resp_cnt;
        nav = 0;
        bad = 1'b0;
        bq.push_back('{4, 0, 32'hABCD_0123, AXI_RESP_OKAY});
        sb.push_back('{32'hABCD_0123, 1'b0});
        send_req(32'h0000_1007);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (resp_valid === 1'b1) break;
            if (axi.M_ARVALID === 1'b1) begin
                nav++;
                if (axi.M_ARADDR !== 32'h0000_1004) bad = 1'b1;
            end
        end
        wait_resp(c0 + 1, ok);
        vectors++;
        if (!ok || nav != 5 || bad) begin
            miscompares++;
            $display("FAIL ar_stall: got resp=%0d arvalid_cycles=%0d addr_bad=%0d, required 1 5 0",
                     ok, nav, bad);
        end
        vectors++;
        if (ar_hs_cnt - h0 != 1) begin
            miscompares++;
            $display("FAIL ar_count: got %0d handshakes, required 1", ar_hs_cnt - h0);
        end
        tick();
    endtask

    task automatic test_err();
        int c0;
        bit ok;
        c0 = resp_cnt;
        bq.push_back('{0, 0, 32'hFFFF_FFFF, AXI_RESP_SLVERR});
        sb.push_back('{32'h0, 1'b1});
        bq.push_back('{1, 2, 32'h1234_567F, AXI_RESP_DECERR});
        sb.push_back('{32'h0, 1'b1});
        send_req(32'h0000_2F00);
        wait_resp(c0 + 1, ok);
        tick();
        send_req(32'h0000_2F08);
        wait_resp(c0 + 2, ok);
        repeat (4) tick();
        vectors++;
        if (!ok || resp_cnt != c0 + 2 || resp_data !== 32'h0 || resp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_resp: got ok=%0d pulses=%0d d=%h e=%b, required 1 2 0 1",
                     ok, resp_cnt - c0, resp_data, resp_err);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        bit ok, seen;
        c0 = resp_cnt;
        seen = 1'b0;
        bq.push_back('{0, 1, 32'h1111_0001, AXI_RESP_OKAY});
        sb.push_back('{32'h1111_0001, 1'b0});
        bq.push_back('{0, 0, 32'h2222_0001, AXI_RESP_OKAY});
        sb.push_back('{32'h2222_0001, 1'b0});
        send_req(32'h0000_1000);
        tick();
        send_req(32'h0000_2000);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen || axi.M_ARVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got seen=%0d arv=%b, required 1 0", seen, axi.M_ARVALID);
        end
        @(negedge CLK);
        vectors++;
        if (axi.M_ARVALID !== 1'b1 || axi.M_ARADDR !== 32'h0000_2000) begin
            miscompares++;
            $display("FAIL b2b_second_ar: got arv=%b ara=%h, required 1 00002000",
                     axi.M_ARVALID, axi.M_ARADDR);
        end
        wait_resp(c0 + 2, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d responses, required 2", resp_cnt - c0);
        end
        tick();
    endtask

    task automatic test_abort();
        int h0, c0, d0;
        bit bad;
        h0 = ar_hs_cnt;
        c0 = resp_cnt;
        d0 = r_done;
        bq.push_back('{4, 0, 32'hDEAD_BEEF, AXI_RESP_OKAY});
        send_req(32'h0000_3000);
        send_req(32'h0000_4000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge CLK);
        vectors++;
        if (axi.M_ARVALID !== 1'b1 || axi.M_ARADDR !== 32'h0000_3000) begin
            miscompares++;
            $display("FAIL abort_ar_held: got arv=%b ara=%h, required 1 00003000",
                     axi.M_ARVALID, axi.M_ARADDR);
        end
        repeat (15) tick();
        @(negedge CLK);
        vectors++;
        if (ar_hs_cnt - h0 != 1 || r_done - d0 != 1 || resp_cnt != c0) begin
            miscompares++;
            $display("FAIL abort_drain: got ar=%0d r=%0d resp=%0d, required 1 1 0",
                     ar_hs_cnt - h0, r_done - d0, resp_cnt - c0);
        end
        vectors++;
        if (axi.M_ARVALID !== 1'b0 || axi.M_RREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got arv=%b rr=%b, required 0 0",
                     axi.M_ARVALID, axi.M_RREADY);
        end
        tick();
        bad = 1'b0;
        abort = 1'b1;
        send_req(32'h0000_7000);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (axi.M_ARVALID !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL abort_idle_req: got ARVALID after aborted request, required none");
        end
        tick();
    endtask

    task automatic test_rst_mid();
        int c0;
        bit ok;
        bq.push_back('{0, 5, 32'h5555_0001, AXI_RESP_OKAY});
        send_req(32'h0000_5000);
        tick();
        RST = 1'b1;
        tick();
        @(negedge CLK);
        slv_kill = 1'b1;
        vectors++;
        if (axi.M_ARVALID !== 1'b0 || axi.M_RREADY !== 1'b0 || axi.M_ARADDR !== 32'h0 ||
            resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got arv=%b rr=%b ara=%h v=%b d=%h e=%b, required all 0",
                     axi.M_ARVALID, axi.M_RREADY, axi.M_ARADDR, resp_valid, resp_data, resp_err);
        end
        RST = 1'b0;
        repeat (3) tick();
        slv_kill = 1'b0;
        tick();
        c0 = resp_cnt;
        bq.push_back('{0, 0, 32'h0000_ABC1, AXI_RESP_OKAY});
        sb.push_back('{32'h0000_ABC1, 1'b0});
        send_req(32'h0000_6000);
        wait_resp(c0 + 1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_recover: got no response, required one");
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_stall();
        test_err();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        repeat (3) tick();
        vectors++;
        if (sb.size() != 0 || bq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d expected responses and %0d beats, required 0 0",
                     sb.size(), bq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
